fft_pingpong_buf: RTL
=====================

// Module: fft_pingpong_buf
// PURPOSE
//  Parametrised two-bank complex ping-pong frame buffer between FFT stages.
//  - Writer fills one bank with sequential samples while the reader drains the other.
//  - Internal write/read counters and per-bank full flags replace the external ODD/address scheme.
//  - Adds input backpressure, overflow detection, frame markers and optional bit-reversed readout.
// PARAMETERS
//  NB  16  real/imag sample width, bits
//  AW  6   address bits per bank; frame length N = 2**AW, total storage 2*N complex words
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  RST_N      in   1   asynchronous active-low reset
//  ED         in   1   global enable; ED=0 freezes all state, pipeline and outputs
//  WE         in   1   write request, one sample per cycle
//  DR         in   NB  write data, real
//  DI         in   NB  write data, imaginary
//  IN_RDY     out  1   write bank free; write accepted iff ED&WE&IN_RDY
//  OVF        out  1   sticky: a write arrived with ED&WE&~IN_RDY; cleared only by reset
//  RD_EN      in   1   read request; issues one read per cycle while a full bank exists
//  DOR        out  NB  read data, real
//  DOI        out  NB  read data, imaginary
//  OUT_VLD    out  1   DOR/DOI valid this cycle
//  OUT_START  out  1   with OUT_VLD: first sample of a frame
//  OUT_LAST   out  1   with OUT_VLD: last sample of a frame
// BEHAVIOUR
//  Reset: wr_bank=0, rd_bank=0, full[1:0]=0, wcnt=rcnt=0, IN_RDY=1, OVF=0,
//   OUT_VLD=OUT_START=OUT_LAST=0, DOR=DOI=0. RAM contents are not reset.
//  Reset mid-frame discards all buffered and in-flight data; no OUT_VLD follows.
//  IN_RDY = ~full[wr_bank] (combinational from registered flags).
//  Write, on accept: mem[wr_bank][wcnt] <= {DR,DI}; wcnt++.
//   At wcnt==N-1: full[wr_bank]<=1, wr_bank toggles, wcnt wraps to 0.
//  Overflow: ED&WE&~IN_RDY -> sample dropped, OVF<=1, no other state change.
//  Read issue: ED&RD_EN&full[rd_bank] -> address {rd_bank, raddr(rcnt)} registered; rcnt++.
//   At rcnt==N-1: full[rd_bank]<=0, rd_bank toggles, rcnt wraps to 0.
//  Read latency: fixed 2 enabled cycles, issue to OUT_VLD (address reg -> output reg).
//   OUT_START/OUT_LAST track rcnt==0 / rcnt==N-1 through the same pipe.
//  RD_EN is a request, not backpressure: in-flight reads always complete (max 2 after RD_EN drops).
//  RD_EN low or no full bank -> no issue, rcnt holds; OUT_VLD=0 after the pipe drains.
//  DOR/DOI hold their last value when OUT_VLD=0.
//  Bank set full and other bank cleared in the same cycle: both updates apply (different banks).
//   Writer may write the freed bank on the next cycle.
//  Read and write never target the same bank.
//   Writer only uses ~full banks, reader only full ones, so no read/write collision exists.
//  Both banks full: IN_RDY=0 until the reader finishes its bank.
//   Frame order is preserved: reader always drains the bank filled first.
//  Memory: one inferred 2-port sync RAM, 2*N x 2*NB.
//   Bank bit is the address MSB; address map: {bank, addr}.
// CONFIGURATION
//  FFT_PPBUF_BITREV_EN defined: raddr(rcnt) = bit-reverse of rcnt over AW bits.
//   Frame is read in bit-reversed order (FFT output reorder).
//   OUT_START/OUT_LAST still mark the 1st/Nth read issued.
//  Not defined: raddr(rcnt) = rcnt, natural order. Write order is natural in both cases.
// TESTING (AW=3, N=8, NB=16 unless noted)
//  1 Reset state: RST_N=0 then release -> IN_RDY=1, OVF=0, OUT_VLD=0, DOR=DOI=0.
//  2 Single frame: write DR=k, DI=-k for k=0..7 with RD_EN=1.
//    -> OUT_VLD from 2 cycles after the 9th cycle, DOR=0..7 natural order.
//    -> OUT_START on k=0, OUT_LAST on k=7.
//  3 Backpressure and overflow: RD_EN=0, write 17 samples.
//    -> IN_RDY=0 after the 16th, 17th dropped, OVF=1.
//    -> Then RD_EN=1: 16 samples out, frame 0 first; IN_RDY=1 the cycle after the 8th issue.
//  4 Continuous streaming: WE=RD_EN=1 for 10 frames.
//    -> Gap-free OUT_VLD after the first frame; IN_RDY never 0; OVF=0; data order exact.
//  5 ED gating and reset mid-frame: toggle ED 0/1 each cycle during a frame.
//    -> Same output sequence, stretched 2x.
//    -> Assert RST_N mid-read: OUT_VLD=0 immediately and no stale data afterwards.
//  6 FFT_PPBUF_BITREV_EN defined: write 0..7.
//    -> Read DOR = 0,4,2,6,1,5,3,7; repeat with AW=6 checking all 64 entries.

Source files
------------

// File: rtl/fft_pingpong_buf.sv
// Two-bank complex ping-pong frame buffer between FFT stages.
// Define FFT_PPBUF_BITREV_EN for bit-reversed frame readout.
module fft_pingpong_buf #(
  parameter int NB = 16,
  parameter int AW = 6
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ED,
  input  logic          WE,
  input  logic [NB-1:0] DR,
  input  logic [NB-1:0] DI,
  output logic          IN_RDY,
  output logic          OVF,
  input  logic          RD_EN,
  output logic [NB-1:0] DOR,
  output logic [NB-1:0] DOI,
  output logic          OUT_VLD,
  output logic          OUT_START,
  output logic          OUT_LAST
);

  localparam int N = 1 << AW;

  logic [2*NB-1:0] mem [2*N];

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;
  logic [AW-1:0] raddr;
  logic          wr_acc;
  logic          rd_iss;
  logic          wr_wrap;
  logic          rd_wrap;
  logic [AW:0]   addr_q;
  logic          v1;
  logic          s1;
  logic          l1;

  assign IN_RDY  = ~full[wr_bank];
  assign wr_acc  = ED & WE & IN_RDY;
  assign rd_iss  = ED & RD_EN & full[rd_bank];
  assign wr_wrap = (wcnt == '1);
  assign rd_wrap = (rcnt == '1);

`ifdef FFT_PPBUF_BITREV_EN
  always_comb begin
    raddr = '0;
    for (int i = 0; i < AW; i++)
      raddr[i] = rcnt[AW-1-i];
  end
`else
  assign raddr = rcnt;
`endif

  // Set and clear always hit different banks, so both apply.
  always_comb begin
    full_n = full;
    if (wr_acc && wr_wrap)
      full_n[wr_bank] = 1'b1;
    if (rd_iss && rd_wrap)
      full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (wr_acc)
      mem[{wr_bank, wcnt}] <= {DR, DI};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      OVF       <= 1'b0;
      addr_q    <= '0;
      v1        <= 1'b0;
      s1        <= 1'b0;
      l1        <= 1'b0;
      OUT_VLD   <= 1'b0;
      OUT_START <= 1'b0;
      OUT_LAST  <= 1'b0;
      DOR       <= '0;
      DOI       <= '0;
    end else if (ED) begin
      full <= full_n;
      if (wr_acc) begin
        wcnt <= wcnt + 1'b1;
        if (wr_wrap)
          wr_bank <= ~wr_bank;
      end
      if (WE && !IN_RDY)
        OVF <= 1'b1;
      if (rd_iss) begin
        rcnt   <= rcnt + 1'b1;
        addr_q <= {rd_bank, raddr};
        s1     <= (rcnt == '0);
        l1     <= rd_wrap;
        if (rd_wrap)
          rd_bank <= ~rd_bank;
      end
      v1        <= rd_iss;
      OUT_VLD   <= v1;
      OUT_START <= v1 & s1;
      OUT_LAST  <= v1 & l1;
      if (v1)
        {DOR, DOI} <= mem[addr_q];
    end
  end

endmodule
